// File: rtl/eth_pkg.sv
// ----------------------------------------------------------------------------
// eth_pkg
// Shared definitions for the Ethernet transmit frame finisher and the
// byte-wide CRC-32 engine (also used by the receive-side FCS checker).
//   tx_state_e      : frame finisher states (data pass-through, pad, FCS)
//   CRC32_POLY_REFL : IEEE 802.3 CRC-32 polynomial, bit-reflected form
//   CRC32_INIT      : CRC register preset at the start of every frame
//   ETH_MIN_LEN     : minimum frame length before the FCS, in bytes
// ----------------------------------------------------------------------------
package eth_pkg;

    typedef enum logic [1:0] {
        S_DATA = 2'd0,
        S_PAD  = 2'd1,
        S_FCS  = 2'd2
    } tx_state_e;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam int          ETH_MIN_LEN     = 60;

endpackage : eth_pkg

// File: rtl/eth_crc32_d8.sv
// ----------------------------------------------------------------------------
// eth_crc32_d8
// Combinational CRC-32 update for one byte, reflected (LSB-first) form.
// The caller owns the CRC register, its preset and the final complement.
// Ports:
//   crc_i  [31:0] : current CRC register value
//   data_i [7:0]  : byte to absorb, bit 0 first
//   crc_o  [31:0] : CRC register value after absorbing data_i
// ----------------------------------------------------------------------------
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_v;

    // Eight serial LFSR steps unrolled into one combinational cone. In the
    // reflected form the data byte is folded into the low byte up front and
    // the register shifts right, feeding back the polynomial on a set LSB.
    always_comb begin
        crc_v = crc_i ^ {24'd0, data_i};
        for (int i = 0; i < 8; i++) begin
            if (crc_v[0]) begin
                crc_v = (crc_v >> 1) ^ CRC32_POLY_REFL;
            end else begin
                crc_v = crc_v >> 1;
            end
        end
        crc_o = crc_v;
    end

endmodule : eth_crc32_d8

// File: rtl/eth_tx_pad_fcs.sv
// ----------------------------------------------------------------------------
// eth_tx_pad_fcs
// Transmit frame finisher between the LLC header encoder and the MAC/PHY.
// Header+payload bytes pass straight through; short frames are zero-padded
// up to MIN_LEN (when PAD_EN is set) and the 4-byte CRC-32 FCS is appended,
// least-significant byte first. Completed frames are counted.
// Parameters:
//   PAD_EN  : 1 pads short frames to MIN_LEN, 0 sends FCS right after data
//   MIN_LEN : minimum length before the FCS, 1..2047
// Ports:
//   clki, rsti         : clock, synchronous active-high reset
//   s_axis_tvalid/tready/tlast/tdata : upstream byte stream (tlast = last
//                        header+payload byte)
//   m_axis_tvalid/tready/tlast/tdata : downstream byte stream (tlast only on
//                        the final FCS byte)
//   frame_cnt_o [31:0] : completed frames, wraps at 2^32
// ----------------------------------------------------------------------------
module eth_tx_pad_fcs
    import eth_pkg::*;
#(
    parameter bit PAD_EN  = 1'b1,
    parameter int MIN_LEN = ETH_MIN_LEN
) (
    input  logic        clki,
    input  logic        rsti,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic [7:0]  s_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [7:0]  m_axis_tdata,
    output logic [31:0] frame_cnt_o
);

    // One bit wider than the byte counter so that byte_cnt+1 never wraps,
    // even with MIN_LEN at its 2047 maximum.
    localparam logic [11:0] MIN_LEN_W = 12'(MIN_LEN);

    tx_state_e   state_q;
    logic [31:0] crc_q;
    logic [10:0] byte_cnt_q;
    logic [1:0]  fcs_idx_q;
    logic [31:0] frame_cnt_q;

    logic [31:0] crc_d;
    logic [31:0] fcs;
    logic [7:0]  fcs_byte;
    logic [11:0] cnt_inc;
    logic [10:0] cnt_sat;
    logic        beat;

    // ------------------------------------------------------------------------
    // Output steering. In S_DATA the block is a wire from s_axis to m_axis;
    // in S_PAD/S_FCS everything comes from registered state so it holds
    // steady across downstream stalls.
    // ------------------------------------------------------------------------
    assign fcs = ~crc_q;

    always_comb begin
        fcs_byte = fcs[7:0];
        case (fcs_idx_q)
            2'd0:    fcs_byte = fcs[7:0];
            2'd1:    fcs_byte = fcs[15:8];
            2'd2:    fcs_byte = fcs[23:16];
            default: fcs_byte = fcs[31:24];
        endcase
    end

    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 8'h00;
        m_axis_tlast  = 1'b0;
        s_axis_tready = 1'b0;
        case (state_q)
            S_DATA: begin
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tdata  = s_axis_tdata;
                s_axis_tready = m_axis_tready;
            end
            S_PAD: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = 8'h00;
            end
            S_FCS: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = fcs_byte;
                m_axis_tlast  = (fcs_idx_q == 2'd3);
            end
            default: begin
                m_axis_tvalid = 1'b0;
            end
        endcase
    end

    // A downstream beat; in S_DATA this is also the upstream handshake.
    assign beat = m_axis_tvalid && m_axis_tready;

    // The CRC absorbs whatever byte goes out during data and pad, so padding
    // is covered by the FCS exactly as the receiver will see it.
    eth_crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (m_axis_tdata),
        .crc_o  (crc_d)
    );

    assign cnt_inc = {1'b0, byte_cnt_q} + 12'd1;
    assign cnt_sat = (cnt_inc >= MIN_LEN_W) ? MIN_LEN_W[10:0] : cnt_inc[10:0];

    // ------------------------------------------------------------------------
    // Frame FSM and counters. Only beats advance anything, so a stall freezes
    // the whole block.
    // ------------------------------------------------------------------------
    always_ff @(posedge clki) begin
        if (rsti) begin
            state_q     <= S_DATA;
            crc_q       <= CRC32_INIT;
            byte_cnt_q  <= 11'd0;
            fcs_idx_q   <= 2'd0;
            frame_cnt_q <= 32'd0;
        end else if (beat) begin
            case (state_q)
                S_DATA: begin
                    crc_q      <= crc_d;
                    byte_cnt_q <= cnt_sat;
                    if (s_axis_tlast) begin
                        // Pad only if this last byte still leaves the frame short.
                        if (PAD_EN && (cnt_inc < MIN_LEN_W)) begin
                            state_q <= S_PAD;
                        end else begin
                            state_q <= S_FCS;
                        end
                    end
                end
                S_PAD: begin
                    crc_q      <= crc_d;
                    byte_cnt_q <= cnt_sat;
                    if (cnt_inc >= MIN_LEN_W) begin
                        state_q <= S_FCS;
                    end
                end
                S_FCS: begin
                    if (fcs_idx_q == 2'd3) begin
                        frame_cnt_q <= frame_cnt_q + 32'd1;
                        crc_q       <= CRC32_INIT;
                        byte_cnt_q  <= 11'd0;
                        fcs_idx_q   <= 2'd0;
                        state_q     <= S_DATA;
                    end else begin
                        fcs_idx_q <= fcs_idx_q + 2'd1;
                    end
                end
                default: begin
                    state_q <= S_DATA;
                end
            endcase
        end
    end

    assign frame_cnt_o = frame_cnt_q;

endmodule : eth_tx_pad_fcs

// File: tb/tb_eth_tx_pad_fcs.sv
module tb_eth_tx_pad_fcs;

    logic        clk;
    logic        rst;
    logic        s_tvalid;
    logic        s_tlast;
    logic [7:0]  s_tdata;
    logic        m_tready;

    // Instance 0: PAD_EN = 0, instance 1: PAD_EN = 1.
    logic        s_rdy0, mv0, ml0;
    logic [7:0]  md0;
    logic [31:0] fc0;
    logic        s_rdy1, mv1, ml1;
    logic [7:0]  md1;
    logic [31:0] fc1;

    bit          sel;
    logic        s_rdy, mv, ml;
    logic [7:0]  md;
    logic [31:0] fc;

    assign s_rdy = sel ? s_rdy1 : s_rdy0;
    assign mv    = sel ? mv1 : mv0;
    assign ml    = sel ? ml1 : ml0;
    assign md    = sel ? md1 : md0;
    assign fc    = sel ? fc1 : fc0;

    eth_tx_pad_fcs #(.PAD_EN(1'b0), .MIN_LEN(60)) u_nopad (
        .clki          (clk),
        .rsti          (rst),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_rdy0),
        .s_axis_tlast  (s_tlast),
        .s_axis_tdata  (s_tdata),
        .m_axis_tvalid (mv0),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (ml0),
        .m_axis_tdata  (md0),
        .frame_cnt_o   (fc0)
    );

    eth_tx_pad_fcs #(.PAD_EN(1'b1), .MIN_LEN(60)) u_pad (
        .clki          (clk),
        .rsti          (rst),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_rdy1),
        .s_axis_tlast  (s_tlast),
        .s_axis_tdata  (s_tdata),
        .m_axis_tvalid (mv1),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (ml1),
        .m_axis_tdata  (md1),
        .frame_cnt_o   (fc1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  in_bytes [0:255];
    logic [31:0] crc_tbl  [0:255];
    logic [7:0]  out_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  ref_q[$];
    bit          last_q[$];
    bit          sr_q[$];
    int          cyc_q[$];
    int          acc_cnt;
    int          stall_bad;
    logic [31:0] fcs_got;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Table-driven software CRC-32 (reflected, preset all-ones).
    function automatic void build_tbl();
        logic [31:0] c;
        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tbl[i] = c;
        end
    endfunction

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [7:0] ix;
        ix = c[7:0] ^ b;
        return (c >> 8) ^ crc_tbl[ix];
    endfunction

    function automatic void build_exp(input int n, input int nf, input bit pad);
        logic [31:0] c;
        int          len;
        exp_q.delete();
        for (int f = 0; f < nf; f++) begin
            c   = 32'hFFFFFFFF;
            len = 0;
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(in_bytes[f*n+i]);
                c = crc_upd(c, in_bytes[f*n+i]);
                len++;
            end
            if (pad) begin
                while (len < 60) begin
                    exp_q.push_back(8'h00);
                    c = crc_upd(c, 8'h00);
                    len++;
                end
            end
            c = ~c;
            for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
        end
    endfunction

    task automatic do_reset();
        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Streams nf frames of n bytes each from in_bytes into the selected
    // instance, collecting every downstream beat. Entered and left #1 after
    // a rising edge.
    task automatic run_frame(input string tag, input int n, input int nf, input bit bp,
                             input int max_cyc, input bit need_done);
        int         idx;
        int         cyc;
        int         tl;
        bit         prev_stall;
        logic [7:0] prev_d;
        logic       prev_l;
        idx = 0; cyc = 0; tl = 0; prev_stall = 1'b0; prev_d = 8'h00; prev_l = 1'b0;
        out_q.delete(); last_q.delete(); sr_q.delete(); cyc_q.delete();
        acc_cnt = 0;
        while (tl < nf && cyc < max_cyc) begin
            s_tvalid = (idx < n*nf);
            s_tdata  = (idx < n*nf) ? in_bytes[idx] : 8'h00;
            s_tlast  = (idx < n*nf) && ((idx % n) == n - 1);
            m_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (prev_stall && (!mv || md !== prev_d || ml !== prev_l)) stall_bad++;
            prev_stall = mv && !m_tready;
            prev_d     = md;
            prev_l     = ml;
            if (mv && m_tready) begin
                out_q.push_back(md);
                last_q.push_back(ml);
                sr_q.push_back(s_rdy);
                cyc_q.push_back(cyc);
                if (ml) tl++;
            end
            if (s_tvalid && s_rdy) begin
                idx++;
                acc_cnt++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        if (need_done) check({tag, "_done"}, 32'(tl >= nf), 32'd1);
    endtask

    task automatic verify(input string tag, input int exp_beats, input int nf);
        int          bad;
        int          nl;
        int          sz;
        int          e;
        logic [31:0] exp_fcs;
        bad = 0; nl = 0;
        sz = out_q.size();
        e  = exp_q.size();
        check({tag, "_beats"}, 32'(sz), 32'(exp_beats));
        for (int i = 0; i < sz; i++) begin
            if (i >= e || out_q[i] !== exp_q[i]) bad++;
            if (last_q[i]) nl++;
        end
        check({tag, "_bytes"}, 32'(bad), 32'd0);
        check({tag, "_tlast_cnt"}, 32'(nl), 32'(nf));
        check({tag, "_tlast_end"}, 32'((sz > 0) ? last_q[sz-1] : 1'b0), 32'd1);
        fcs_got = (sz >= 4) ? {out_q[sz-1], out_q[sz-2], out_q[sz-3], out_q[sz-4]} : 32'd0;
        exp_fcs = {exp_q[e-1], exp_q[e-2], exp_q[e-3], exp_q[e-4]};
        check({tag, "_fcs"}, fcs_got, exp_fcs);
    endtask

    task automatic load_hdr16();
        logic [7:0] h [0:15];
        h = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
              8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02,
              8'hFF, 8'h01, 8'hAA, 8'h55};
        for (int i = 0; i < 16; i++) in_bytes[i] = h[i];
    endtask

    task automatic load_123();
        for (int i = 0; i < 9; i++) in_bytes[i] = 8'(8'h31 + i);
    endtask

    initial begin
        int lens [0:2];
        int beats[0:2];
        int cnt;
        build_tbl();
        sel       = 1'b1;
        stall_bad = 0;
        s_tdata   = 8'hA5;
        s_tlast   = 1'b1;
        s_tvalid  = 1'b0;
        m_tready  = 1'b1;
        rst       = 1'b1;

        // Reset state: pass-through control, no tlast, counter cleared.
        repeat (2) @(posedge clk);
        #1;
        s_tvalid = 1'b1;
        @(negedge clk);
        check("rst_mvalid_hi", 32'(mv1), 32'd1);
        check("rst_tdata", 32'(md1), 32'hA5);
        check("rst_tlast", 32'(ml1), 32'd0);
        check("rst_sready_hi", 32'(s_rdy1), 32'd1);
        check("rst_fcnt", fc1, 32'd0);
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        #1;
        check("rst_mvalid_lo", 32'(mv1), 32'd0);
        check("rst_sready_lo", 32'(s_rdy1), 32'd0);
        @(posedge clk); #1;
        rst      = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;

        // FCS only: "123456789" -> 26 39 F4 CB.
        sel = 1'b0;
        load_123();
        run_frame("crc9", 9, 1, 1'b0, 100, 1'b1);
        build_exp(9, 1, 1'b0);
        verify("crc9", 13, 1);
        check("crc9_fcs_const", fcs_got, 32'hCBF43926);
        check("crc9_fcnt", fc0, 32'd1);

        // Padded 16-byte frame.
        do_reset();
        sel = 1'b1;
        load_hdr16();
        run_frame("pad16", 16, 1, 1'b0, 200, 1'b1);
        build_exp(16, 1, 1'b1);
        verify("pad16", 64, 1);
        check("pad16_accepted", 32'(acc_cnt), 32'd16);
        cnt = 0;
        for (int i = 16; i < sr_q.size(); i++) if (sr_q[i]) cnt++;
        check("pad16_sready_low", 32'(cnt), 32'd0);
        check("pad16_fcnt", fc1, 32'd1);
        ref_q = out_q;

        // Length boundaries around MIN_LEN.
        lens  = '{59, 60, 61};
        beats = '{64, 64, 65};
        for (int i = 0; i < 64; i++) in_bytes[i] = 8'(i * 3 + 1);
        for (int t = 0; t < 3; t++) begin
            run_frame($sformatf("len%0d", lens[t]), lens[t], 1, 1'b0, 200, 1'b1);
            build_exp(lens[t], 1, 1'b1);
            verify($sformatf("len%0d", lens[t]), beats[t], 1);
        end
        check("len_fcnt", fc1, 32'd4);

        // Random downstream backpressure over the padded frame.
        load_hdr16();
        stall_bad = 0;
        run_frame("bp16", 16, 1, 1'b1, 1000, 1'b1);
        build_exp(16, 1, 1'b1);
        verify("bp16", 64, 1);
        cnt = 0;
        for (int i = 0; i < out_q.size() && i < ref_q.size(); i++) if (out_q[i] !== ref_q[i]) cnt++;
        check("bp16_vs_nostall", 32'(cnt), 32'd0);
        check("bp16_stall_stable", 32'(stall_bad), 32'd0);
        check("bp16_fcnt", fc1, 32'd5);

        // Reset in the middle of padding.
        run_frame("rstpad", 16, 1, 1'b0, 25, 1'b0);
        rst      = 1'b1;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstpad_mvalid_lo", 32'(mv1), 32'd0);
        check("rstpad_sready_hi", 32'(s_rdy1), 32'd1);
        check("rstpad_fcnt", fc1, 32'd0);
        s_tvalid = 1'b1;
        m_tready = 1'b0;
        #1;
        check("rstpad_mvalid_hi", 32'(mv1), 32'd1);
        check("rstpad_sready_lo", 32'(s_rdy1), 32'd0);
        check("rstpad_tlast", 32'(ml1), 32'd0);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        load_123();
        run_frame("rst_pad9", 9, 1, 1'b0, 200, 1'b1);
        build_exp(9, 1, 1'b1);
        verify("rst_pad9", 64, 1);
        sel = 1'b0;
        run_frame("rst_nopad9", 9, 1, 1'b0, 100, 1'b1);
        build_exp(9, 1, 1'b0);
        verify("rst_nopad9", 13, 1);
        check("rst_nopad9_fcs_const", fcs_got, 32'hCBF43926);

        // Back-to-back 64-byte frames.
        do_reset();
        sel = 1'b1;
        for (int i = 0; i < 128; i++) in_bytes[i] = 8'(i * 5 + 7);
        run_frame("b2b", 64, 2, 1'b0, 400, 1'b1);
        build_exp(64, 2, 1'b1);
        verify("b2b", 136, 2);
        check("b2b_gap", 32'((cyc_q.size() > 68) ? (cyc_q[68] - cyc_q[67]) : 0), 32'd1);
        check("b2b_fcnt", fc1, 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_eth_tx_pad_fcs
